// File: rtl/pipe_ctrl_if.sv
// Pipeline control interface between the execute stage / external bus master
// and pipe_ctrl. The master modport is the requesting side; slave is pipe_ctrl.
// When PIPE_CTRL_PERF_EN is defined, the performance counter signals are added.
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        bus_req_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        hold_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        bus_gnt_o;
  logic        hold_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr_i;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_events_o;
`endif

  modport master (
`ifdef PIPE_CTRL_PERF_EN
    output perf_clr_i,
    input  stall_cycles_o, flush_events_o,
`endif
    output jump_en_i, jump_addr_i, hold_flag_i, bus_req_i,
    input  jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
    input  flush_if_id_o, flush_id_ex_o, bus_gnt_o, hold_timeout_o
  );

  modport slave (
`ifdef PIPE_CTRL_PERF_EN
    input  perf_clr_i,
    output stall_cycles_o, flush_events_o,
`endif
    input  jump_en_i, jump_addr_i, hold_flag_i, bus_req_i,
    output jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
    output flush_if_id_o, flush_id_ex_o, bus_gnt_o, hold_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: redirect/flush after taken jumps, execute
// holds with optional timeout, and pipeline freeze for an external bus master.
// Optional macro PIPE_CTRL_PERF_EN adds stall-cycle and redirect counters.
//
// state    | meaning
// RUN      | normal flow, accepts jump / hold / bus requests in that priority
// FLUSH    | post-redirect squash, flushes high until flush_cnt runs out
// EX_HOLD  | execute multi-cycle hold, all stages frozen
// BUS_HOLD | external master owns the pipeline, all stages frozen
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave pif
);

  localparam logic [7:0] HT_C    = (HOLD_TIMEOUT > 255) ? 8'd255 : 8'(HOLD_TIMEOUT);
  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, FLUSH, EX_HOLD, BUS_HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d, hold_cnt_inc;
  logic        ign_q, ign_d;
  logic        gnt_q, tout_q;
  logic        redirect;
  logic        jump_en_c, hold_c, flush_c;
  logic [31:0] jump_addr_c;

  // State, counters and the registered grant / timeout outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      hold_cnt_q  <= 8'd0;
      ign_q       <= 1'b0;
      gnt_q       <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      ign_q       <= ign_d;
      gnt_q       <= (state_d == BUS_HOLD);
      // Pulse lands in the cycle after HOLD_TIMEOUT held cycles; that cycle
      // forces the holds low and returns to RUN.
      tout_q      <= (state_d == EX_HOLD) && (HT_C != 8'd0) && (hold_cnt_d == HT_C);
    end
  end

  // Next-state and combinational controls; jump always wins when accepted.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    hold_cnt_d   = 8'd0;
    ign_d        = ign_q && pif.hold_flag_i;
    jump_en_c    = 1'b0;
    jump_addr_c  = 32'h0;
    hold_c       = 1'b0;
    flush_c      = 1'b0;
    hold_cnt_inc = (hold_cnt_q == 8'hff) ? 8'hff : hold_cnt_q + 8'd1;
    redirect     = ((state_q == RUN) || (state_q == EX_HOLD)) && pif.jump_en_i;

    if (redirect) begin
      jump_en_c   = 1'b1;
      jump_addr_c = pif.jump_addr_i;
      flush_c     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FC_INIT;
      end else begin
        state_d     = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pif.hold_flag_i && !ign_q) begin
            hold_c     = 1'b1;
            hold_cnt_d = hold_cnt_inc;
            state_d    = EX_HOLD;
          end else if (pif.bus_req_i) begin
            state_d    = BUS_HOLD;
          end
        end
        EX_HOLD: begin
          if (!pif.hold_flag_i) begin
            state_d = RUN;
          end else if ((HT_C != 8'd0) && (hold_cnt_q == HT_C)) begin
            state_d = RUN;
            ign_d   = 1'b1;
          end else begin
            hold_c     = 1'b1;
            hold_cnt_d = hold_cnt_inc;
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        BUS_HOLD: begin
          hold_c = 1'b1;
          if (!pif.bus_req_i) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Combinational outputs read as zero while reset is held.
  assign pif.jump_en_o      = rst_n & jump_en_c;
  assign pif.jump_addr_o    = rst_n ? jump_addr_c : 32'h0;
  assign pif.hold_pc_o      = rst_n & hold_c;
  assign pif.hold_if_id_o   = rst_n & hold_c;
  assign pif.hold_id_ex_o   = rst_n & hold_c;
  assign pif.flush_if_id_o  = rst_n & flush_c;
  assign pif.flush_id_ex_o  = rst_n & flush_c;
  assign pif.bus_gnt_o      = gnt_q;
  assign pif.hold_timeout_o = tout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] fev_q;

  // Wrapping stall-cycle and redirect counters, synchronously clearable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      fev_q   <= 16'd0;
    end else if (pif.perf_clr_i) begin
      stall_q <= 32'd0;
      fev_q   <= 16'd0;
    end else begin
      if (hold_c || flush_c) stall_q <= stall_q + 32'd1;
      if (jump_en_c)         fev_q   <= fev_q + 16'd1;
    end
  end

  assign pif.stall_cycles_o = stall_q;
  assign pif.flush_events_o = fev_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised bench for pipe_ctrl: two instances (FLUSH_CYCLES=2/HOLD_TIMEOUT=255
// and FLUSH_CYCLES=3/HOLD_TIMEOUT=3) share stimulus and are checked each cycle
// against a cycle-level behavioural model of the controller rules.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if if0 ();
  pipe_ctrl_if if1 ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(255)) u_dut0 (.clk(clk), .rst_n(rst_n), .pif(if0));
  pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_TIMEOUT(3))   u_dut1 (.clk(clk), .rst_n(rst_n), .pif(if1));

  // {jump_en, jump_addr[31:0], holds[2:0], flushes[1:0], gnt, timeout}
  logic [39:0] obs [2];
  assign obs[0] = {if0.jump_en_o, if0.jump_addr_o, if0.hold_pc_o, if0.hold_if_id_o,
                   if0.hold_id_ex_o, if0.flush_if_id_o, if0.flush_id_ex_o,
                   if0.bus_gnt_o, if0.hold_timeout_o};
  assign obs[1] = {if1.jump_en_o, if1.jump_addr_o, if1.hold_pc_o, if1.hold_if_id_o,
                   if1.hold_id_ex_o, if1.flush_if_id_o, if1.flush_id_ex_o,
                   if1.bus_gnt_o, if1.hold_timeout_o};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: remaining flush cycles, grant owned, held-cycle count, hold blocked
  int m_flush [2];
  bit m_gnt   [2];
  int m_held  [2];
  bit m_blk   [2];

  function automatic int fc_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int ht_of(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0; m_gnt[k] = 0; m_held[k] = 0; m_blk[k] = 0;
    end
  endtask

  task automatic drive(input bit j, input logic [31:0] a, input bit h, input bit b);
    if0.jump_en_i = j; if0.jump_addr_i = a; if0.hold_flag_i = h; if0.bus_req_i = b;
    if1.jump_en_i = j; if1.jump_addr_i = a; if1.hold_flag_i = h; if1.bus_req_i = b;
  endtask

  // One clock cycle: drive, let logic settle, compare against model, advance model.
  task automatic step(input bit j, input logic [31:0] a, input bit h, input bit b);
    bit ej, eh, ef, eg, et, in_hold, gnt_n, blk_n;
    logic [31:0] ea;
    @(negedge clk);
    drive(j, a, h, b);
    #1;
    for (int k = 0; k < 2; k++) begin
      ej = 0; ea = 32'h0; eh = 0; ef = 0; et = 0;
      eg = m_gnt[k];
      gnt_n = m_gnt[k];
      blk_n = h ? m_blk[k] : 1'b0;
      if (m_flush[k] > 0) begin
        ef = 1;
        m_flush[k]--;
      end else if (m_gnt[k]) begin
        eh = 1;
        if (!b) gnt_n = 0;
      end else begin
        in_hold = (m_held[k] > 0);
        et = in_hold && (m_held[k] == ht_of(k));
        if (j) begin
          ej = 1; ea = a; ef = 1;
          m_flush[k] = fc_of(k) - 1;
          m_held[k] = 0;
        end else if (et && h) begin
          m_held[k] = 0;
          blk_n = 1;
        end else if (h && (in_hold || !m_blk[k])) begin
          eh = 1;
          m_held[k] = (m_held[k] >= 255) ? 255 : m_held[k] + 1;
        end else begin
          m_held[k] = 0;
          if (b && !in_hold) gnt_n = 1;
        end
      end
      m_gnt[k] = gnt_n;
      m_blk[k] = blk_n;
      chk($sformatf("d%0d_jump_en", k), 32'(obs[k][39]), 32'(ej));
      chk($sformatf("d%0d_jump_addr", k), obs[k][38:7], ea);
      chk($sformatf("d%0d_holds", k), 32'(obs[k][6:4]), eh ? 32'd7 : 32'd0);
      chk($sformatf("d%0d_flushes", k), 32'(obs[k][3:2]), ef ? 32'd3 : 32'd0);
      chk($sformatf("d%0d_bus_gnt", k), 32'(obs[k][1]), 32'(eg));
      chk($sformatf("d%0d_timeout", k), 32'(obs[k][0]), 32'(et));
    end
  endtask

  // Pull reset low between edges with all requests active; outputs must be 0 at once.
  task automatic rst_mid();
    @(negedge clk);
    drive(1'b1, 32'hdead_beef, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("d%0d_rst_outputs", k), 32'(obs[k] != 40'd0), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("d%0d_rst_hold", k), 32'(obs[k] != 40'd0), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit rh, rb;
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (10) step(0, 32'h0, 0, 0);

    // Redirect, then a squashed jump during FLUSH
    step(1, 32'h0000_0040, 0, 0);
    step(1, 32'h0000_0080, 0, 0);
    repeat (4) step(0, 32'h0, 0, 0);

    // Execute hold 5 cycles, then 10 cycles (timeout on instance 1)
    repeat (5) step(0, 32'h0, 1, 0);
    repeat (3) step(0, 32'h0, 0, 0);
    repeat (10) step(0, 32'h0, 1, 0);
    repeat (3) step(0, 32'h0, 0, 0);

    // Bus grant for 4 cycles, then a grant with a jump inside it
    repeat (4) step(0, 32'h0, 0, 1);
    repeat (3) step(0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    step(1, 32'h0000_1234, 1, 1);
    step(0, 32'h0, 0, 1);
    repeat (3) step(0, 32'h0, 0, 0);

    // All three requests together; grant follows once FLUSH is done
    step(1, 32'h0000_0100, 1, 1);
    repeat (5) step(0, 32'h0, 0, 1);
    repeat (3) step(0, 32'h0, 0, 0);

    // Long hold reaching the 255-cycle timeout on instance 0
    repeat (260) step(0, 32'h0, 1, 0);
    repeat (3) step(0, 32'h0, 0, 0);

    // Reset during FLUSH, then during BUS_HOLD
    step(1, 32'h0000_0200, 0, 0);
    rst_mid();
    repeat (4) step(0, 32'h0, 0, 0);
    repeat (3) step(0, 32'h0, 0, 1);
    rst_mid();
    repeat (4) step(0, 32'h0, 0, 0);

    // Randomised traffic with sticky hold / bus request runs
    rh = 0; rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rh = ~rh;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      step(($urandom_range(0, 9) == 0), $urandom, rh, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

`ifdef PIPE_CTRL_PERF_EN
  initial begin
    if0.perf_clr_i = 1'b0;
    if1.perf_clr_i = 1'b0;
  end
`endif

endmodule
